// File: rtl/wb_sched_pkg.sv
// Shared types for the Wishbone round-robin scheduler: FSM states, CTI codes, grant encoding.
package wb_sched_pkg;

  localparam int NUM_M = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } grant_t;

  localparam grant_t GRANT_NONE = '0;

  function automatic grant_t grant_enc(input logic [IDX_W-1:0] idx);
    grant_t g;
    g.vld = 1'b1;
    g.idx = idx;
    return g;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requester after last_i (wrapping); last_i itself ranks lowest.
module rr_pick (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic       vld_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    vld_o = |req_i;
    idx_o = last_i;
    cand  = last_i;
    for (int i = 4; i >= 1; i--) begin
      cand = last_i + 2'(i);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/wb_rr_sched.sv
// Four-master round-robin Wishbone scheduler: registered grant held for the owner's whole cycle,
// zero-dead-cycle handover, and a stalled-slave watchdog that aborts the owner with err.
module wb_rr_sched
  import wb_sched_pkg::*;
#(
  parameter int              c_DATA_WIDTH = 64,
  parameter int              NUM_M        = wb_sched_pkg::NUM_M,
  parameter int              TO_W         = 12,
  parameter logic [TO_W-1:0] TIMEOUT      = 12'd2048,
  localparam int             SEL_W        = c_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_M-1:0]          m_en_i,
  input  logic [NUM_M-1:0]          m_cyc_i,
  input  logic [NUM_M-1:0]          m_stb_i,
  input  logic [NUM_M-1:0]          m_we_i,
  input  logic [32*NUM_M-1:0]       m_adr_i,
  input  logic [NUM_M*c_DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_M*SEL_W-1:0]    m_sel_i,
  input  logic [3*NUM_M-1:0]        m_cti_i,
  output logic [c_DATA_WIDTH-1:0]   m_dat_o,
  output logic [NUM_M-1:0]          m_ack_o,
  output logic [NUM_M-1:0]          m_err_o,
  output logic [NUM_M-1:0]          m_rty_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [31:0]               s_adr_o,
  output logic [c_DATA_WIDTH-1:0]   s_dat_o,
  output logic [SEL_W-1:0]          s_sel_o,
  output logic [2:0]                s_cti_o,
  input  logic [c_DATA_WIDTH-1:0]   s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [2:0]                grant_o,
  output logic                      timeout_o
);

  state_e          state_q;
  grant_t          gnt_q;
  logic [1:0]      last_q;
  logic [TO_W-1:0] wd_q;
  logic [TO_W-1:0] wd_d;

  logic [1:0]       g;
  logic [NUM_M-1:0] g_oh;
  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] pk_req;
  logic [1:0]       pk_last;
  logic             pk_vld;
  logic [1:0]       pk_idx;
  logic             busy;
  logic             stall;
  logic             to_hit;

  assign g    = gnt_q.idx;
  assign g_oh = {{(NUM_M-1){1'b0}}, 1'b1} << g;
  assign req  = m_cyc_i & m_en_i;

  // While someone owns the bus, the owner is masked so it cannot win its own release.
  assign pk_req  = (state_q == IDLE) ? req : (req & ~g_oh);
  assign pk_last = (state_q == IDLE) ? last_q : g;

  rr_pick u_pick (
    .req_i  (pk_req),
    .last_i (pk_last),
    .vld_o  (pk_vld),
    .idx_o  (pk_idx)
  );

  assign busy    = (state_q == BUSY);
  assign s_cyc_o = busy & m_cyc_i[g];
  assign s_stb_o = busy & m_cyc_i[g] & m_stb_i[g];
  assign s_we_o  = m_we_i[g];
  assign s_adr_o = m_adr_i[32*g +: 32];
  assign s_dat_o = m_dat_i[c_DATA_WIDTH*g +: c_DATA_WIDTH];
  assign s_sel_o = m_sel_i[SEL_W*g +: SEL_W];
  assign s_cti_o = m_cti_i[3*g +: 3];

  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = busy ? (g_oh & {NUM_M{s_ack_i}}) : '0;
  assign m_rty_o   = busy ? (g_oh & {NUM_M{s_rty_i}}) : '0;
  assign m_err_o   = busy ? (g_oh & {NUM_M{s_err_i}}) : ((state_q == ABORT) ? g_oh : '0);
  assign timeout_o = (state_q == ABORT);
  assign grant_o   = gnt_q;

  // Any termination in the would-be timeout cycle clears stall and so cancels the abort.
  assign stall  = s_stb_o & ~(s_ack_i | s_err_i | s_rty_i);
  assign wd_d   = stall ? (wd_q + TO_W'(1)) : '0;
  assign to_hit = (TIMEOUT != '0) && stall && (wd_d == (TIMEOUT - TO_W'(1)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= GRANT_NONE;
      last_q  <= 2'd3;
      wd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pk_vld) begin
            state_q <= BUSY;
            gnt_q   <= grant_enc(pk_idx);
          end
        end
        BUSY, DRAIN: begin
          if (!m_cyc_i[g]) begin
            last_q <= g;
            wd_q   <= '0;
            if (pk_vld) begin
              state_q <= BUSY;
              gnt_q   <= grant_enc(pk_idx);
            end else begin
              state_q <= IDLE;
              gnt_q   <= GRANT_NONE;
            end
          end else if (state_q == BUSY) begin
            if (to_hit) begin
              state_q <= ABORT;
              wd_q    <= '0;
            end else begin
              wd_q <= wd_d;
            end
          end
        end
        ABORT:   state_q <= DRAIN;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_rr_sched.md
Name: wb_rr_sched

Overview:
Four-master round-robin Wishbone scheduler that shares one slave port (the bus-matrix ingress) between the PCIe, SGDMA and two auxiliary masters.
- Grant is registered. It is held for the whole m_cyc_i of the owner, so bursts are never split.
- A stalled-slave watchdog returns err to the owner, so a dead slave cannot hang the bus.
- Sits between the masters and the existing address-decode arbiter.

Parameters:
c_DATA_WIDTH, 64, data bus width
NUM_M, 4, number of masters (fixed 4 in this revision)
TO_W, 12, watchdog counter width
TIMEOUT, 12'd2048, cycles of unterminated stb before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
m_en_i  in  4  per-master arbitration enable
m_cyc_i  in  4  master cycle requests
m_stb_i  in  4  master strobes
m_we_i  in  4  master write enables
m_adr_i  in  128  packed addresses, master k in [32k+31:32k]
m_dat_i  in  4*c_DATA_WIDTH  packed write data
m_sel_i  in  32  packed byte selects
m_cti_i  in  12  packed cycle type ids
m_dat_o  out  c_DATA_WIDTH  read data, broadcast to all masters
m_ack_o  out  4  per-master ack
m_err_o  out  4  per-master err
m_rty_o  out  4  per-master rty
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave strobes
s_adr_o  out  32  slave address
s_dat_o  out  c_DATA_WIDTH  slave write data
s_sel_o  out  8  slave byte select
s_cti_o  out  3  slave cycle type
s_dat_i  in  c_DATA_WIDTH  slave read data
s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations
grant_o  out  3  {valid, index[1:0]} of current owner
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rstn low at posedge clk):
  - state IDLE, grant_o 3'b000, last-owner pointer 3, watchdog 0, timeout_o 0.
  - All s_cyc/s_stb and m_ack/err/rty are 0.
  - Master 0 has first priority after reset.
  - Reset mid-transfer drops s_cyc_o on the next edge; no termination is issued to the master.
- Request set req = m_cyc_i & m_en_i. Pick = first set bit of req searching from (last+1) mod 4 upward.
- States:
  - IDLE: no owner. If req!=0, register owner=pick and go to BUSY. This gives 1 cycle of latency from cyc to s_cyc_o.
  - BUSY:
    - s_cyc_o = m_cyc_i[g]; s_stb_o = m_cyc_i[g] & m_stb_i[g]; s_adr/dat/sel/cti/we muxed from g.
    - m_ack_o[g]/m_err_o[g]/m_rty_o[g] = s_ack_i/s_err_i/s_rty_i (combinational). All other masters see 0.
  - BUSY exit, when m_cyc_i[g]=0:
    - last<=g.
    - If req excluding g is nonzero, owner<=pick (computed with the updated rotation) and stay in BUSY. This is zero-dead-cycle handover; the new master drives the slave the next cycle.
    - If req excluding g is zero, go to IDLE.
    - g is never re-granted while another master requests.
  - Watchdog (BUSY only): counter increments each cycle with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i, and clears on any termination or when stb is low. When it reaches TIMEOUT-1 with TIMEOUT!=0, go to ABORT.
  - ABORT (1 cycle): s_cyc_o=s_stb_o=0, m_err_o[g]=1, timeout_o=1, watchdog cleared. Then go to DRAIN.
  - DRAIN: s_cyc_o=0, all terminations 0. When m_cyc_i[g]=0, apply the BUSY release rules above.
- Enable rules:
  - Clearing m_en_i[g] during ownership does not revoke the grant; it takes effect at release.
  - Disabled masters never receive ack/err/rty.
- Simultaneous events:
  - Release and a new request in the same cycle follow the release rule.
  - s_ack_i in the timeout cycle cancels the abort; the ack is passed through.
- m_dat_o = s_dat_i always (broadcast). Masters qualify it by their own ack.
- Unused CTI encodings are passed through unmodified; burst end is determined by m_cyc_i only.

Decomposition:
- Shared package wb_sched_pkg:
  - state enum {IDLE, BUSY, ABORT, DRAIN}
  - CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111)
  - NUM_M
  - grant encoding
- One sub-module rr_pick: 4-bit rotating priority encoder (req, last → valid, idx). It is reused by later matrix ports.

Test Plan:
- Reset with all m_cyc_i=1, then release → grant_o=3'b100 (master 0) two cycles after rstn rises; s_cyc_o=1 on the same cycle.
- Masters 0..3 all hold cyc; each drops cyc after 4 acks → grant sequence 0,1,2,3,0 with no idle cycle between owners.
- Master 1 issues an 8-beat INCR burst while master 2 requests → master 2 granted only after m_cyc_i[1] falls; all 8 acks go to master 1; m_ack_o[2]=0 throughout.
- TIMEOUT=16, slave never acks → m_err_o[g] and timeout_o pulse exactly at cycle 16 of stb; s_cyc_o=0 until the master drops cyc, then the next requester is granted.
- m_en_i=4'b1011 with master 2 requesting alone → grant stays invalid and s_cyc_o=0; clearing m_en_i[0] while master 0 owns → ownership kept until cyc drop.
- rstn low for one cycle mid-burst → s_cyc_o=0 and grant_o=0 on the next cycle, no ack/err emitted, and arbitration restarts at master 0.
